// File: rtl/scope_pkg.sv
// Shared types and helpers for the scope capture engine: FSM state
// encoding, screen geometry and the sample-to-row conversion.
package scope_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        WAIT = 3'd2,
        POST = 3'd3,
        DONE = 3'd4
    } state_e;

    localparam int SCREEN_ROWS = 480;

    // Converts a signed sample to a screen row: positive samples move up
    // from the centre line. The product is formed at 64 bits so no
    // parameter combination can overflow before the shift, and the result
    // is clamped to the visible rows.
    function automatic logic [9:0] y_row(input longint s, input longint apix,
                                         input longint center_y, input int shift);
        longint prod;
        longint y;
        prod = (s * apix) >>> shift;
        y    = center_y - prod;
        if (y < 0) return 10'd0;
        if (y > longint'(SCREEN_ROWS - 1)) return 10'(SCREEN_ROWS - 1);
        return 10'(y);
    endfunction

endpackage

// File: rtl/scope_sample_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
module scope_sample_ram #(
    parameter int DEPTH = 640,
    parameter int W     = 8
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_q;

    // Write port and registered read port; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/scope_capture.sv
// Multi-channel edge-triggered capture with pre-trigger history and a
// double-buffered store; a finished capture is shown only at frame_done.
// Optional build macro SCOPE_AUTO_TRIG_EN: forced trigger after
// AUTO_TIMEOUT accepted samples in WAIT.
//
// state | meaning
// IDLE  | stopped, waiting for run
// PRE   | filling PRETRIG samples of history
// WAIT  | writing continuously, looking for the trigger edge
// POST  | filling the rest of the window after the trigger
// DONE  | capture complete, waiting for a frame boundary to swap
module scope_capture
    import scope_pkg::*;
#(
    parameter int NCH          = 2,
    parameter int W            = 8,
    parameter int DEPTH        = 640,
    parameter int PRETRIG      = 64,
    parameter int CENTER_Y     = 239,
    parameter int APIX         = 180,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic                                   CLOCK_50,
    input  logic                                   reset,
    input  logic                                   sample_valid,
    input  logic [NCH*W-1:0]                       sample_data,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] trig_ch,
    input  logic [W-1:0]                           trig_level,
    input  logic                                   trig_rising,
    input  logic                                   run,
    input  logic [7:0]                             decim,
    input  logic                                   frame_done,
    input  logic [$clog2(DEPTH)-1:0]               rd_addr,
    output logic [NCH*10-1:0]                      rd_pix,
    output logic                                   rd_valid,
    output logic [2:0]                             state,
    output logic                                   triggered,
    output logic                                   auto_trig
);

    localparam int AW      = $clog2(DEPTH);
    localparam int TW      = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNT_MAX = (DEPTH > AUTO_TIMEOUT) ? DEPTH : AUTO_TIMEOUT;
    localparam int CNTW    = $clog2(CNT_MAX + 1);
    localparam logic [CNTW-1:0] PRE_LAST  = CNTW'(PRETRIG - 1);
    localparam logic [CNTW-1:0] POST_LAST = CNTW'(DEPTH - PRETRIG - 1);
`ifdef SCOPE_AUTO_TRIG_EN
    localparam logic [CNTW-1:0] AUTO_LAST = CNTW'(AUTO_TIMEOUT - 1);
`endif
    localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);
    localparam logic [AW:0] PRE_X   = (AW+1)'(PRETRIG);
    localparam logic [AW:0] BACK_X  = (AW+1)'(DEPTH - PRETRIG);

    state_e              state_q, state_d;
    logic [7:0]          dec_q, dec_d;
    logic [AW-1:0]       wp_q, wp_d, start_q, start_d, offset_q, offset_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic                bank_q, bank_d, bank_rd_q;
    logic                rd_valid_q, rd_valid_d, auto_q, auto_d, triggered_q;
    logic [NCH*W-1:0]    prev_q, prev_d;
    logic                prev_vld_q, prev_vld_d;
    logic [NCH*10-1:0]   rd_pix_q, rd_pix_d;
    logic                accept, wr_en, trig_fire, enter_pre, edge_hit;
    logic signed [W-1:0] cur_s, prv_s, lvl_s;
    logic [AW:0]         wp_x, rsum;
    logic [AW-1:0]       start_calc, raddr;
    logic [W-1:0]        rdata [2][NCH];
    logic signed [W-1:0] front_s [NCH];

    assign accept = sample_valid && (dec_q == decim);
    assign wr_en  = accept && (state_q == PRE || state_q == WAIT || state_q == POST);
    assign lvl_s  = trig_level;

    // Trigger channel selection for the current and previous sample.
    always_comb begin
        cur_s = sample_data[W-1:0];
        prv_s = prev_q[W-1:0];
        for (int c = 0; c < NCH; c++) begin
            if (trig_ch == TW'(c)) begin
                cur_s = sample_data[c*W +: W];
                prv_s = prev_q[c*W +: W];
            end
        end
    end

    assign edge_hit = prev_vld_q && (trig_rising ? (prv_s <  lvl_s && cur_s >= lvl_s)
                                                 : (prv_s >= lvl_s && cur_s <  lvl_s));

    // Window start is PRETRIG samples behind the trigger sample, modulo DEPTH.
    assign wp_x       = {1'b0, wp_q};
    assign start_calc = (wp_x >= PRE_X) ? AW'(wp_x - PRE_X) : AW'(wp_x + BACK_X);

    // Next-state logic for the capture FSM and its bookkeeping registers.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        start_d    = start_q;
        offset_d   = offset_q;
        bank_d     = bank_q;
        rd_valid_d = rd_valid_q;
        auto_d     = auto_q;
        trig_fire  = 1'b0;
        enter_pre  = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d   = PRE;
                    enter_pre = 1'b1;
                end
            end
            PRE: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == PRE_LAST) begin
                        state_d = WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            WAIT: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (edge_hit) begin
                        trig_fire = 1'b1;
                        auto_d    = 1'b0;
                    end
`ifdef SCOPE_AUTO_TRIG_EN
                    else if (cnt_q == AUTO_LAST) begin
                        trig_fire = 1'b1;
                        auto_d    = 1'b1;
                    end
`endif
                    if (trig_fire) begin
                        state_d = POST;
                        start_d = start_calc;
                        cnt_d   = CNTW'(1);
                    end
                end
            end
            POST: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == POST_LAST) state_d = DONE;
                end
            end
            DONE: begin
                if (frame_done) begin
                    bank_d     = ~bank_q;
                    offset_d   = start_q;
                    rd_valid_d = 1'b1;
                    if (run) begin
                        state_d   = PRE;
                        enter_pre = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (enter_pre) cnt_d = '0;
    end

    // Decimation counter, write pointer and edge-detect history.
    always_comb begin
        dec_d      = dec_q;
        wp_d       = wp_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        if (enter_pre)         dec_d = '0;
        else if (sample_valid) dec_d = accept ? 8'd0 : dec_q + 8'd1;
        if (wr_en) begin
            wp_d   = (wp_q == AW'(DEPTH - 1)) ? '0 : wp_q + 1'b1;
            prev_d = sample_data;
        end
        if (enter_pre)  prev_vld_d = 1'b0;
        else if (wr_en) prev_vld_d = 1'b1;
    end

    // Control and status registers.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= IDLE;
            dec_q       <= '0;
            wp_q        <= '0;
            start_q     <= '0;
            offset_q    <= '0;
            cnt_q       <= '0;
            bank_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            auto_q      <= 1'b0;
            triggered_q <= 1'b0;
            prev_q      <= '0;
            prev_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dec_q       <= dec_d;
            wp_q        <= wp_d;
            start_q     <= start_d;
            offset_q    <= offset_d;
            cnt_q       <= cnt_d;
            bank_q      <= bank_d;
            rd_valid_q  <= rd_valid_d;
            auto_q      <= auto_d;
            triggered_q <= trig_fire;
            prev_q      <= prev_d;
            prev_vld_q  <= prev_vld_d;
        end
    end

    // Display column to physical address, rotated by the latched window start.
    assign rsum  = {1'b0, rd_addr} + {1'b0, offset_q};
    assign raddr = (rsum >= DEPTH_X) ? AW'(rsum - DEPTH_X) : rsum[AW-1:0];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        for (genvar c = 0; c < NCH; c++) begin : g_ch
            scope_sample_ram #(.DEPTH(DEPTH), .W(W)) u_ram (
                .clk_i   (CLOCK_50),
                .we_i    (wr_en && (bank_q != 1'(b))),
                .waddr_i (wp_q),
                .wdata_i (sample_data[c*W +: W]),
                .raddr_i (raddr),
                .rdata_o (rdata[b][c])
            );
        end
    end

    // Front-bank select aligned to the RAM read stage, then row scaling.
    always_comb begin
        rd_pix_d = '0;
        for (int c = 0; c < NCH; c++) begin
            front_s[c] = bank_rd_q ? rdata[1][c] : rdata[0][c];
            rd_pix_d[c*10 +: 10] = y_row(longint'(front_s[c]), longint'(APIX),
                                         longint'(CENTER_Y), W - 1);
        end
    end

    // Read pipeline registers.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            bank_rd_q <= 1'b0;
            rd_pix_q  <= '0;
        end else begin
            bank_rd_q <= bank_q;
            rd_pix_q  <= rd_pix_d;
        end
    end

    assign rd_pix    = rd_pix_q;
    assign rd_valid  = rd_valid_q;
    assign state     = state_q;
    assign triggered = triggered_q;
    assign auto_trig = auto_q;

endmodule
